// File: rtl/lossless_rle_coder_pkg.sv
// Shared definitions for the zigzag run-length coder: FSM state encoding,
// token constants and the 10-bit value saturation helper.
package lossless_rle_coder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SCAN,
    S_EOB,
    S_HEADER,
    S_DONE
  } rle_state_type;

  localparam logic [15:0] RLE_EOB = 16'h0000;
  localparam int          VAL_MAX = 511;
  localparam int          VAL_MIN = -512;

  // Clamp a signed coefficient into the 10-bit token value field.
  function automatic logic [9:0] saturate_val(input logic signed [15:0] c);
    if (int'(c) > VAL_MAX)      return 10'h1FF;
    else if (int'(c) < VAL_MIN) return 10'h200;
    else                        return c[9:0];
  endfunction

endpackage

// File: rtl/lossless_rle_coder_zigzag_lut.sv
// Standard JPEG zigzag order: scan position k -> row-major index inside an 8x8 block.
module zigzag_lut (
  input  logic [5:0] k,
  output logic [5:0] idx
);

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  assign idx = ZZ[k];

endmodule

// File: rtl/lossless_rle_coder.sv
// Reads quantized 8x8 DCT blocks from SRAM, scans them in zigzag order and writes
// {run, val} tokens (EOB-terminated per block) plus a token-count header back to SRAM.
module lossless_rle_coder
  import lossless_rle_coder_pkg::*;
#(
  parameter int          NUM_BLOCKS = 2400,
  parameter logic [19:0] COEFF_BASE = 20'd76800,
  parameter logic [19:0] OUT_BASE   = 20'd230400,
  parameter int          READ_LAT   = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        enable,
  output logic        finished,
  input  logic [15:0] SRAM_read_data,
  output logic [19:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  localparam logic [11:0] LAST_BLK = 12'(NUM_BLOCKS - 1);
  localparam logic [3:0]  LAT_LAST = 4'(READ_LAT - 1);

  rle_state_type state, next_state;

  logic [11:0] blk;
  logic [5:0]  rd_i;
  logic [3:0]  lat_cnt;
  logic [5:0]  k;
  logic [5:0]  run;
  logic [19:0] out_ptr;
  logic [17:0] tok_cnt;

  logic [15:0] coef_buf [64];
  logic [READ_LAT:0] tag_v;
  logic [5:0]  tag_idx [READ_LAT+1];
  logic [5:0]  zz_idx;
  logic [15:0] coef;

  zigzag_lut u_zigzag (
    .k   (k),
    .idx (zz_idx)
  );

  assign coef = coef_buf[zz_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (enable)               next_state = S_READ;
      S_READ:   if (rd_i == 6'd63)        next_state = S_DRAIN;
      S_DRAIN:  if (lat_cnt == LAT_LAST)  next_state = S_SCAN;
      S_SCAN:   if (k == 6'd63)           next_state = S_EOB;
      S_EOB:    next_state = (blk == LAST_BLK) ? S_HEADER : S_READ;
      S_HEADER: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Read tags follow each issued address so the sample READ_LAT cycles later lands in the right slot.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) tag_v <= '0;
    else       tag_v <= {tag_v[READ_LAT-1:0], state == S_READ};
  end

  // NOTE: the coefficient buffer and tag indices carry no reset; every slot is
  // rewritten by the read phase of each block before the scan consumes it.
  // The final sample arrives one cycle into the scan, long before k=63 needs it.
  always_ff @(posedge Clock) begin
    tag_idx[0] <= rd_i;
    for (int s = 1; s <= READ_LAT; s++) tag_idx[s] <= tag_idx[s-1];
    if (tag_v[READ_LAT]) coef_buf[tag_idx[READ_LAT]] <= SRAM_read_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      finished        <= 1'b0;
      blk             <= '0;
      rd_i            <= '0;
      lat_cnt         <= '0;
      k               <= '0;
      run             <= '0;
      out_ptr         <= '0;
      tok_cnt         <= '0;
    end else begin
      SRAM_we_n <= 1'b1;
      finished  <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          blk     <= '0;
          rd_i    <= '0;
          out_ptr <= OUT_BASE + 20'd1;
          tok_cnt <= '0;
        end
        S_READ: begin
          SRAM_address <= COEFF_BASE + {2'b00, blk, rd_i};
          rd_i         <= rd_i + 6'd1;
          lat_cnt      <= '0;
        end
        S_DRAIN: begin
          lat_cnt <= lat_cnt + 4'd1;
          k       <= '0;
          run     <= '0;
        end
        S_SCAN: begin
          k <= k + 6'd1;
          if (coef != 16'h0000) begin
            SRAM_address    <= out_ptr;
            SRAM_write_data <= {run, saturate_val(coef)};
            SRAM_we_n       <= 1'b0;
            out_ptr         <= out_ptr + 20'd1;
            tok_cnt         <= tok_cnt + 18'd1;
            run             <= '0;
          end else begin
            run <= run + 6'd1;
          end
        end
        S_EOB: begin
          SRAM_address    <= out_ptr;
          SRAM_write_data <= RLE_EOB;
          SRAM_we_n       <= 1'b0;
          out_ptr         <= out_ptr + 20'd1;
          tok_cnt         <= tok_cnt + 18'd1;
          rd_i            <= '0;
          if (blk != LAST_BLK) blk <= blk + 12'd1;
        end
        S_HEADER: begin
          SRAM_address    <= OUT_BASE;
          SRAM_write_data <= tok_cnt[15:0];
          SRAM_we_n       <= 1'b0;
        end
        S_DONE:  finished <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lossless_rle_coder.sv
// Self-checking bench: directed single-block vectors, randomized three-block runs
// against a zigzag/RLE reference model, and a reset abort during block 1.
module tb_lossless_rle_coder;

  localparam logic [19:0] COEFF_BASE = 20'd76800;
  localparam logic [19:0] OUT_BASE   = 20'd230400;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a, rst_b, en_a, en_b;
  logic        fin_a, fin_b, we_a, we_b;
  logic [19:0] addr_a, addr_b;
  logic [15:0] wd_a, wd_b, rd_a, rd_b;
  logic [15:0] pa1, pa2, pb1, pb2;

  // Coefficient memories are written only by the stimulus; output memories only by the SRAM models.
  bit [15:0] coef_a [bit [19:0]];
  bit [15:0] coef_b [bit [19:0]];
  bit [31:0] out_a  [bit [19:0]];
  bit [31:0] out_b  [bit [19:0]];
  bit [15:0] gen_a = 16'd1, gen_b = 16'd1;
  int wr_cnt_a = 0, wr_cnt_b = 0, fin_cnt_a = 0, fin_cnt_b = 0;

  int checks = 0, errors = 0;
  int cur [3][64];
  int zz_tb [64];
  logic [15:0] exp_q [$];

  lossless_rle_coder #(.NUM_BLOCKS(1)) dut_a (
    .Clock(clk), .Reset(rst_a), .enable(en_a), .finished(fin_a),
    .SRAM_read_data(rd_a), .SRAM_address(addr_a), .SRAM_write_data(wd_a), .SRAM_we_n(we_a));

  lossless_rle_coder #(.NUM_BLOCKS(3)) dut_b (
    .Clock(clk), .Reset(rst_b), .enable(en_b), .finished(fin_b),
    .SRAM_read_data(rd_b), .SRAM_address(addr_b), .SRAM_write_data(wd_b), .SRAM_we_n(we_b));

  // SRAM models: data for an address driven in cycle t is valid during cycle t+2.
  always @(posedge clk) begin pa1 <= coef_a[addr_a]; pa2 <= pa1; end
  always @(posedge clk) begin pb1 <= coef_b[addr_b]; pb2 <= pb1; end
  assign rd_a = pa2;
  assign rd_b = pb2;
  always @(posedge clk) if (we_a === 1'b0) begin out_a[addr_a] = {gen_a, wd_a}; wr_cnt_a++; end
  always @(posedge clk) if (we_b === 1'b0) begin out_b[addr_b] = {gen_b, wd_b}; wr_cnt_b++; end
  always @(posedge clk) if (fin_a === 1'b1) fin_cnt_a++;
  always @(posedge clk) if (fin_b === 1'b1) fin_cnt_b++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {written-this-run, data}; stale entries from earlier runs read as unwritten.
  function automatic logic [16:0] get_out(input bit sel, input logic [19:0] a);
    bit [31:0] e;
    bit [15:0] g;
    e = 32'h0;
    if (sel && out_b.exists(a)) e = out_b[a];
    if (!sel && out_a.exists(a)) e = out_a[a];
    g = sel ? gen_b : gen_a;
    return (e[31:16] == g) ? {1'b1, e[15:0]} : 17'h0;
  endfunction

  function automatic logic [9:0] sat10(input int c);
    int v;
    v = (c > 511) ? 511 : ((c < -512) ? -512 : c);
    return v[9:0];
  endfunction

  // Zigzag order derived by walking the anti-diagonals of the 8x8 block.
  task automatic build_zigzag();
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_tb[n] = r * 8 + (s - r); n++; end
      else            for (int r = lo; r <= hi; r++) begin zz_tb[n] = r * 8 + (s - r); n++; end
    end
  endtask

  task automatic build_expected(input int nb);
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      int run;
      run = 0;
      for (int k = 0; k < 64; k++) begin
        int c;
        c = cur[b][zz_tb[k]];
        if (c != 0) begin exp_q.push_back({6'(run), sat10(c)}); run = 0; end
        else run++;
      end
      exp_q.push_back(16'h0000);
    end
  endtask

  task automatic load(input bit sel, input int nb);
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 64; i++) begin
        if (sel) coef_b[COEFF_BASE + 20'(64 * b + i)] = 16'(cur[b][i]);
        else     coef_a[COEFF_BASE + 20'(64 * b + i)] = 16'(cur[b][i]);
      end
    if (sel) gen_b++; else gen_a++;
  endtask

  task automatic run_dut(input bit sel, input int extra_en_at, input string tag);
    int f0;
    bit ok;
    f0 = sel ? fin_cnt_b : fin_cnt_a;
    @(negedge clk); if (sel) en_b = 1'b1; else en_a = 1'b1;
    @(negedge clk); en_a = 1'b0; en_b = 1'b0;
    ok = 1'b0;
    for (int c = 1; c <= 3000 && !ok; c++) begin
      @(negedge clk);
      en_a = (!sel && c == extra_en_at);
      en_b = (sel && c == extra_en_at);
      if ((sel ? fin_cnt_b : fin_cnt_a) != f0) ok = 1'b1;
    end
    en_a = 1'b0; en_b = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, " finished seen"}, 32'(ok), 32'd1);
    check({tag, " finished pulses"}, (sel ? fin_cnt_b : fin_cnt_a) - f0, 32'd1);
  endtask

  task automatic compare_out(input bit sel, input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s tok%0d", tag, i), 32'(get_out(sel, OUT_BASE + 20'(1 + i))), {15'h0, 1'b1, exp_q[i]});
    check({tag, " header"}, 32'(get_out(sel, OUT_BASE)), {15'h0, 1'b1, 16'(exp_q.size())});
    check({tag, " no extra write"}, 32'(get_out(sel, OUT_BASE + 20'(1 + exp_q.size()))), 32'h0);
  endtask

  task automatic random_fill(input int pct);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) begin
        cur[b][i] = 0;
        if ($urandom_range(99) < pct) begin
          cur[b][i] = ($urandom_range(1) == 1) ? int'($urandom_range(6000)) - 3000
                                               : int'($urandom_range(40)) - 20;
          if (cur[b][i] == 0) cur[b][i] = 1;
        end
      end
  endtask

  typedef struct {
    string       name;
    int          p0, v0, p1, v1;
    int          ntok;
    logic [15:0] t0, t1, t2;
    logic [15:0] hdr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int nb0, w0, w1;
    bit reached;
    logic [15:0] et [3];

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    build_zigzag();
    #5;
    check("reset we_n a", 32'(we_a), 32'd1);
    check("reset addr a", 32'(addr_a), 32'd0);
    check("reset wdata a", 32'(wd_a), 32'd0);
    check("reset finished a", 32'(fin_a), 32'd0);
    check("reset we_n b", 32'(we_b), 32'd1);
    check("reset finished b", 32'(fin_b), 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{"all_zero", -1, 0, -1, 0,     1, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    vecs[1] = '{"dc5",       0, 5, -1, 0,     2, 16'h0005, 16'h0000, 16'h0000, 16'h0002};
    vecs[2] = '{"run2",      8, 7, -1, 0,     2, 16'h0807, 16'h0000, 16'h0000, 16'h0002};
    vecs[3] = '{"last_m1",  63, -1, -1, 0,    2, 16'hFFFF, 16'h0000, 16'h0000, 16'h0002};
    vecs[4] = '{"sat",       0, 1000, 1, -2000, 3, 16'h01FF, 16'h0200, 16'h0000, 16'h0003};
    vecs[5] = '{"bounds",    9, -512, 2, 511,   3, 16'h1200, 16'h01FF, 16'h0000, 16'h0003};

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 64; i++) cur[0][i] = 0;
      if (vecs[v].p0 >= 0) cur[0][vecs[v].p0] = vecs[v].v0;
      if (vecs[v].p1 >= 0) cur[0][vecs[v].p1] = vecs[v].v1;
      load(1'b0, 1);
      run_dut(1'b0, (v == 1) ? 40 : 0, vecs[v].name);
      et[0] = vecs[v].t0; et[1] = vecs[v].t1; et[2] = vecs[v].t2;
      for (int i = 0; i < vecs[v].ntok; i++)
        check($sformatf("%s tok%0d", vecs[v].name, i), 32'(get_out(1'b0, OUT_BASE + 20'(1 + i))), {15'h0, 1'b1, et[i]});
      check({vecs[v].name, " header"}, 32'(get_out(1'b0, OUT_BASE)), {15'h0, 1'b1, vecs[v].hdr});
      check({vecs[v].name, " no extra write"}, 32'(get_out(1'b0, OUT_BASE + 20'(1 + vecs[v].ntok))), 32'h0);
    end

    for (int t = 0; t < 3; t++) begin
      random_fill((t == 0) ? 5 : ((t == 1) ? 25 : 70));
      load(1'b1, 3);
      build_expected(3);
      w0 = wr_cnt_b;
      run_dut(1'b1, (t == 1) ? 150 : 0, $sformatf("rand%0d", t));
      compare_out(1'b1, $sformatf("rand%0d", t));
      check($sformatf("rand%0d write count", t), wr_cnt_b - w0, 32'(exp_q.size() + 1));
    end

    // Reset during the scan of block 1, then a clean rerun.
    random_fill(30);
    cur[1][0] = 3;
    cur[1][63] = -7;
    load(1'b1, 3);
    build_expected(3);
    nb0 = 0;
    while (exp_q[nb0] != 16'h0000) nb0++;
    nb0++;
    w0 = wr_cnt_b;
    @(negedge clk); en_b = 1'b1;
    @(negedge clk); en_b = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      if (wr_cnt_b - w0 >= nb0 + 1) reached = 1'b1;
    end
    check("abort reached block1 scan", 32'(reached), 32'd1);
    rst_b = 1'b1;
    #1;
    w1 = wr_cnt_b;
    check("abort we_n at reset", 32'(we_b), 32'd1);
    check("abort addr at reset", 32'(addr_b), 32'd0);
    repeat (4) @(negedge clk);
    check("abort writes during reset", wr_cnt_b - w1, 32'd0);
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    check("abort writes after release", wr_cnt_b - w1, 32'd0);
    check("abort we_n idle", 32'(we_b), 32'd1);
    load(1'b1, 3);
    run_dut(1'b1, 0, "rerun");
    compare_out(1'b1, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
